// File: rtl/q_sys_cpu_cpu_mul_pkg.sv
// Shared widths and stage-register layout for the multiplier partial-product combine stage.
// Latency/backpressure live in the top: 2-stage pipe, each stage advances only when its successor frees.
package q_sys_cpu_cpu_mul_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int HALF_W = 16;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/q_sys_cpu_cpu_mult_combine.sv
// Folds three 16x16 partial products into the low word of a*b; result 2 cycles after acceptance.
// Backpressure: B holds under !out_ready, A advances only into a free B, in_ready drops when both are full.
module q_sys_cpu_cpu_mult_combine #(
  parameter int DATA_W = q_sys_cpu_cpu_mul_pkg::DATA_W,
  parameter int TAG_W  = q_sys_cpu_cpu_mul_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_p1,
  input  logic [DATA_W-1:0] in_p2,
  input  logic [DATA_W-1:0] in_p3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_result
);
  import q_sys_cpu_cpu_mul_pkg::*;

  stage_t            a_q, a_d;
  stage_t            b_q, b_d;
  logic [HALF_W-1:0] a_sum_q, a_sum_d;

  logic out_xfer;
  logic b_free;
  logic a_move;
  logic in_xfer;

  // Cross terms only reach the low word through their low halves.
  logic unused_hi;
  assign unused_hi = ^{in_p2[DATA_W-1:HALF_W], in_p3[DATA_W-1:HALF_W]};

  assign out_xfer = b_q.valid && out_ready;
  assign b_free   = !b_q.valid || out_ready;
  assign a_move   = a_q.valid && b_free;
  assign in_ready = !a_q.valid || b_free;
  assign in_xfer  = in_valid && in_ready && !flush;

  always_comb begin
    a_d     = a_q;
    a_sum_d = a_sum_q;
    b_d     = b_q;

    if (a_move) begin
      b_d.valid = 1'b1;
      b_d.tag   = a_q.tag;
      b_d.data  = a_q.data + DATA_W'({a_sum_q, {HALF_W{1'b0}}});
    end else if (out_xfer) begin
      b_d.valid = 1'b0;
    end

    if (in_xfer) begin
      a_d.valid = 1'b1;
      a_d.tag   = in_tag;
      a_d.data  = in_p1;
      a_sum_d   = in_p2[HALF_W-1:0] + in_p3[HALF_W-1:0];
    end else if (a_move) begin
      a_d.valid = 1'b0;
    end

    // Kill only drops occupancy; payload registers keep whatever they captured.
    if (flush) begin
      a_d.valid = 1'b0;
      b_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      a_sum_q <= '0;
      b_q     <= '0;
    end else begin
      a_q     <= a_d;
      a_sum_q <= a_sum_d;
      b_q     <= b_d;
    end
  end

  assign out_valid  = b_q.valid;
  assign out_tag    = b_q.tag;
  assign out_result = b_q.data;

endmodule

// File: tb/tb_q_sys_cpu_cpu_mult_combine.sv
// Bench for the partial-product combine pipe: directed table, stall/flush/reset sequences, random stream vs a*b.
module tb_q_sys_cpu_cpu_mult_combine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_tag = '0;
  logic [31:0] in_p1 = '0, in_p2 = '0, in_p3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_tag;
  logic [31:0] out_result;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  q_sys_cpu_cpu_mult_combine dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .in_p1      (in_p1),
    .in_p2      (in_p2),
    .in_p3      (in_p3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
  task automatic drive(input logic iv, input logic [4:0] tg, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_tag    = tg;
    in_p1     = a;
    in_p2     = b;
    in_p3     = c;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    drive(1'b1, v.tag, v.p1, v.p2, v.p3, 1'b1, 1'b0);
    chk({nm, "_in_ready"}, in_ready, 1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk({nm, "_valid_c1"}, out_valid, 0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk({nm, "_valid_c2"}, out_valid, 1);
    chk({nm, "_result"}, out_result, v.exp);
    chk({nm, "_tag"}, out_tag, v.tag);
  endtask

  initial begin
    logic [36:0] q[$];
    logic [36:0] cur;
    logic [36:0] exp_e;
    logic [63:0] prod;
    logic [31:0] ra, rb, rp1, rp2, rp3;
    logic [4:0]  rtag;
    logic        pend;
    int          sent;
    int          cyc;

    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 5'd3,  32'h0002_0001};
    vecs[1] = '{32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 5'd7,  32'h0000_0001};
    vecs[2] = '{32'h0000_0008, 32'h0000_000A, 32'h0000_000C, 5'd31, 32'h0016_0008};
    vecs[3] = '{32'h0000_0000, 32'hABCD_8000, 32'h1234_8000, 5'd0,  32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd10, 32'h0000_FFFF};
    vecs[5] = '{32'h1234_5678, 32'h0000_1111, 32'h0000_2222, 5'd21, 32'h4567_5678};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall: two accepts fill the pipe, third waits; output held while stalled
    drive(1'b1, 5'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_rdy_t1", in_ready, 1);
    drive(1'b1, 5'd2, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_rdy_t2", in_ready, 1);
    drive(1'b1, 5'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_full_rdy", in_ready, 0);
    chk("stall_ov", out_valid, 1);
    chk("stall_tag_a", out_tag, 1);
    drive(1'b1, 5'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_full_rdy2", in_ready, 0);
    chk("stall_tag_b", out_tag, 1);
    chk("stall_res_b", out_result, 1);
    drive(1'b1, 5'd3, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("stall_pass_rdy", in_ready, 1);
    chk("stall_out1_tag", out_tag, 1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("stall_out2_ov", out_valid, 1);
    chk("stall_out2_tag", out_tag, 2);
    chk("stall_out2_res", out_result, 2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("stall_out3_tag", out_tag, 3);
    chk("stall_out3_res", out_result, 3);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("stall_empty", out_valid, 0);

    // Flush with both stages full and a same-cycle input
    drive(1'b1, 5'd4, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 5'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 5'd6, 32'd6, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush_pre_ov", out_valid, 1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_ov_c1", out_valid, 0);
    chk("flush_rdy_c1", in_ready, 1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_ov_c2", out_valid, 0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_ov_c3", out_valid, 0);

    // Reset mid-stream with a stalled valid result
    drive(1'b1, 5'd9, 32'h55, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mrst_pre_ov", out_valid, 1);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mrst_ov", out_valid, 0);
    chk("mrst_res", out_result, 0);
    chk("mrst_tag", out_tag, 0);
    reset = 1'b0;
    apply_vec(vecs[0], "post_rst");

    // Random stream against the plain a*b model
    pend = 1'b0;
    sent = 0;
    cyc  = 0;
    rp1 = '0; rp2 = '0; rp3 = '0; rtag = '0; cur = '0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      cyc++;
      if (!pend && sent < 10000 && $urandom_range(7) != 0) begin
        ra   = $urandom;
        rb   = $urandom;
        rtag = 5'($urandom_range(31));
        rp1  = {16'h0, ra[15:0]} * {16'h0, rb[15:0]};
        rp2  = {16'h0, ra[15:0]} * {16'h0, rb[31:16]};
        rp3  = {16'h0, ra[31:16]} * {16'h0, rb[15:0]};
        prod = {32'h0, ra} * {32'h0, rb};
        cur  = {rtag, prod[31:0]};
        pend = 1'b1;
      end
      drive(pend, rtag, rp1, rp2, rp3, ($urandom_range(3) != 0), 1'b0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious_out", 1, 0);
        end else begin
          exp_e = q.pop_front();
          chk("rand_result", out_result, exp_e[31:0]);
          chk("rand_tag", out_tag, exp_e[36:32]);
        end
      end
      if (pend && in_ready) begin
        q.push_back(cur);
        sent++;
        pend = 1'b0;
      end
    end
    chk("rand_ops_sent", sent, 10000);
    chk("rand_queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/q_sys_cpu_cpu_mult_combine.md
Q_SYS_CPU_CPU_MULT_COMBINE -- requirements
Module: q_sys_cpu_cpu_mult_combine

Interface
REQ-001 Parameter DATA_W, default 32: operand, partial-product and result width.
REQ-002 Parameter TAG_W, default 5: destination-register tag width.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 flush  input  1: pipeline kill; drops all in-flight operations.
REQ-006 in_valid  input  1: partial products and tag valid this cycle.
REQ-007 in_ready  output  1: block accepts the input this cycle.
REQ-008 in_tag  input  TAG_W: destination tag carried with the operation.
REQ-009 in_p1  input  DATA_W: lo(a)*lo(b), 32-bit unsigned partial product.
REQ-010 in_p2  input  DATA_W: lo(a)*hi(b) partial product.
REQ-011 in_p3  input  DATA_W: hi(a)*lo(b) partial product.
REQ-012 out_valid  output  1: result and tag valid.
REQ-013 out_ready  input  1: downstream (writeback) accepts the result.
REQ-014 out_tag  output  TAG_W: tag of the presented result.
REQ-015 out_result  output  DATA_W: low DATA_W bits of a*b.

Function
REQ-016 Transfer in: in_valid && in_ready && !flush; transfer out: out_valid && out_ready.
REQ-017 Stage A registers p1, tag, and sum16 = (p2[15:0] + p3[15:0]) mod 2^16.
REQ-018 Stage B registers result = (p1 + {sum16, 16'h0}) mod 2^DATA_W, plus tag.
REQ-019 Upper halves p2[31:16] and p3[31:16] are ignored; no carry beyond bit DATA_W-1 is kept.
REQ-020 Latency: out_valid asserts 2 cycles after an input transfer when out_ready is held high.
REQ-021 Throughput: one operation per cycle when out_ready is held high.
REQ-022 Stage B loads from A when B is empty or B transfers out this cycle.
REQ-023 in_ready = !A_valid || (A moves to B this cycle); combinational, with no path from in_valid.
REQ-024 While out_valid && !out_ready: out_result and out_tag are held stable, and out_valid stays high.
REQ-025 Full (A and B valid, out_ready low): in_ready is low; no data is lost or overwritten.
REQ-026 Simultaneous out transfer and input transfer with both stages full: A->B and in->A happen in the same cycle.
REQ-027 flush: A_valid and B_valid clear at the next edge.
REQ-028 flush takes priority over a same-cycle in_valid; that input is dropped.
REQ-029 A same-cycle out transfer during flush still counts as accepted downstream.
REQ-030 Data registers are not cleared by flush; only the valid bits are.
REQ-031 Result ordering equals acceptance order; no reordering.

Reset
REQ-032 On reset: A_valid = 0, B_valid = 0, out_valid = 0.
REQ-033 On reset: out_result = 0 and out_tag = 0.
REQ-034 After reset deasserts: in_ready = 1 in the first cycle.
REQ-035 Reset mid-operation discards all in-flight operations with no output pulse.
REQ-036 Reset takes priority over flush and over all transfers.

Structure
REQ-037 Package q_sys_cpu_cpu_mul_pkg holds DATA_W, TAG_W and the half-width constant (16).
REQ-038 The package also holds the stage-register struct (valid, tag, data).
REQ-039 The block is flat: two stage registers and one adder each; it has no sub-module.

Verification
REQ-040 p1=p2=p3=0x00000001, tag 3, out_ready=1 -> out_result=0x00020001, tag 3, valid exactly 2 cycles later.
REQ-041 p1=p2=p3=0xFFFE0001 (-1*-1) -> out_result=0x00000001 (wrap-around and upper-half discard).
REQ-042 Back-to-back inputs with tags 1,2,3 and out_ready low for 4 cycles -> in_ready drops after 2 accepts; outputs 1,2,3 in order, stable while stalled.
REQ-043 flush asserted with both stages full plus same-cycle in_valid -> no out_valid afterwards; in_ready=1 next cycle.
REQ-044 reset asserted mid-stream with out_valid high -> out_valid=0, out_result=0 next cycle; the next operation behaves per REQ-040.
REQ-045 Random stream of 10k ops with random out_ready -> every result matches the reference model (a*b) mod 2^32, in order.
